// File: rtl/scie_issuer.sv
// scie_issuer: request-side issue/capture wrapper for the pipelined SCIE
// complex-arithmetic unit. Registers each accepted request onto the SCIE
// issue port, tracks it through a LATENCY-deep tag pipeline, captures the
// returned rd one cycle later, and buffers it in a first-word-fall-through
// result FIFO tagged with an 8-bit sequence number. A credit counter keeps
// every in-flight request backed by a free FIFO slot, since SCIE cannot stall.
// Optional feature macro: SCIE_ISSUER_PERF_EN enables the perf counters.
module scie_issuer #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [31:0]        io_in_insn,
  input  logic signed [15:0] io_in_rs1_real,
  input  logic signed [15:0] io_in_rs1_imag,
  input  logic [31:0]        io_in_rs2,
  output logic               io_scie_valid,
  output logic [31:0]        io_scie_insn,
  output logic [31:0]        io_scie_rs2,
  output logic signed [15:0] io_scie_rs1_real,
  output logic signed [15:0] io_scie_rs1_imag,
  input  logic signed [15:0] io_scie_rd_real,
  input  logic signed [15:0] io_scie_rd_imag,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic signed [15:0] io_out_real,
  output logic signed [15:0] io_out_imag,
  output logic [7:0]         io_out_seq,
  output logic [31:0]        io_perf_issued,
  output logic [31:0]        io_perf_stalls
);

  localparam int DATA_W = 16;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          accept;
  logic          pop;
  logic [CW-1:0] used;
  logic [7:0]    seq;

  // Credits are checked against registered occupancy only.
  assign io_in_ready = (used < CW'(DEPTH));
  assign accept      = io_in_valid && io_in_ready;
  assign pop         = io_out_valid && io_out_ready;

  // Credit counter: one credit per request from accept until its result is popped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      used <= '0;
    end else if (accept && !pop) begin
      used <= used + CW'(1);
    end else if (!accept && pop) begin
      used <= used - CW'(1);
    end
  end

  // Sequence tag counter, wraps 255 -> 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq <= 8'd0;
    end else if (accept) begin
      seq <= seq + 8'd1;
    end
  end

  // ---- stage p0: SCIE issue register ----
  logic                     vld_p0;
  logic [31:0]              insn_p0;
  logic [31:0]              rs2_p0;
  logic signed [DATA_W-1:0] re_p0;
  logic signed [DATA_W-1:0] im_p0;
  logic [7:0]               seq_p0;

  // Issue register; data fields hold their last value when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      insn_p0 <= '0;
      rs2_p0  <= '0;
      re_p0   <= '0;
      im_p0   <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        insn_p0 <= io_in_insn;
        rs2_p0  <= io_in_rs2;
        re_p0   <= io_in_rs1_real;
        im_p0   <= io_in_rs1_imag;
      end
    end
  end

  // Sequence tag travelling alongside the issued request.
  always_ff @(posedge clock) begin
    if (accept) begin
      seq_p0 <= seq;
    end
  end

  assign io_scie_valid    = vld_p0;
  assign io_scie_insn     = insn_p0;
  assign io_scie_rs2      = rs2_p0;
  assign io_scie_rs1_real = re_p0;
  assign io_scie_rs1_imag = im_p0;

  // ---- stage p1: tag pipeline matching the SCIE latency ----
  logic [LATENCY-1:0] vld_p1;
  logic [7:0]         seq_p1 [LATENCY];

  // Tag valid shift register; cleared on reset so stale SCIE results are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
      end
    end
  end

  // Tag sequence shift register.
  always_ff @(posedge clock) begin
    seq_p1[0] <= seq_p0;
    for (int i = 1; i < LATENCY; i++) begin
      seq_p1[i] <= seq_p1[i-1];
    end
  end

  // ---- stage p2: rd capture ----
  logic                     vld_p2;
  logic signed [DATA_W-1:0] re_p2;
  logic signed [DATA_W-1:0] im_p2;
  logic [7:0]               seq_p2;

  // Capture valid: rd is sampled in the cycle the tag exits the pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1[LATENCY-1];
    end
  end

  // Capture rd and its tag bit-exact.
  always_ff @(posedge clock) begin
    re_p2  <= io_scie_rd_real;
    im_p2  <= io_scie_rd_imag;
    seq_p2 <= seq_p1[LATENCY-1];
  end

  // ---- result FIFO ----
  logic signed [DATA_W-1:0] mem_re  [DEPTH];
  logic signed [DATA_W-1:0] mem_im  [DEPTH];
  logic [7:0]               mem_seq [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;

  // FIFO storage write; credits guarantee a free slot.
  always_ff @(posedge clock) begin
    if (vld_p2) begin
      mem_re[wr_ptr]  <= re_p2;
      mem_im[wr_ptr]  <= im_p2;
      mem_seq[wr_ptr] <= seq_p2;
    end
  end

  // FIFO pointers and occupancy; write into empty FIFO is visible next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (vld_p2) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (vld_p2 && !pop) begin
        count <= count + CW'(1);
      end else if (!vld_p2 && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign io_out_valid = (count != '0);
  assign io_out_real  = io_out_valid ? mem_re[rd_ptr]  : '0;
  assign io_out_imag  = io_out_valid ? mem_im[rd_ptr]  : '0;
  assign io_out_seq   = io_out_valid ? mem_seq[rd_ptr] : '0;

`ifdef SCIE_ISSUER_PERF_EN
  logic [31:0] issued;
  logic [31:0] stalls;

  // Performance counters: accepted requests and blocked request cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued <= '0;
      stalls <= '0;
    end else begin
      if (accept) begin
        issued <= issued + 32'd1;
      end
      if (io_in_valid && !io_in_ready) begin
        stalls <= stalls + 32'd1;
      end
    end
  end

  assign io_perf_issued = issued;
  assign io_perf_stalls = stalls;
`else
  assign io_perf_issued = 32'd0;
  assign io_perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_scie_issuer.sv
// Testbench for scie_issuer: two instances (LATENCY=1 and LATENCY=4) share
// the request/result inputs; each has its own echo SCIE stub. A queue-based
// reference model tracks expected results, sequence tags and credits.
module tb_scie_issuer;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [31:0]        in_insn = '0;
  logic [31:0]        in_rs2 = '0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;

  logic               a_in_ready, a_scie_valid, a_out_valid;
  logic [31:0]        a_scie_insn, a_scie_rs2, a_perf_issued, a_perf_stalls;
  logic signed [15:0] a_scie_re, a_scie_im, a_rd_re, a_rd_im, a_out_re, a_out_im;
  logic [7:0]         a_out_seq;

  logic               b_in_ready, b_scie_valid, b_out_valid;
  logic [31:0]        b_scie_insn, b_scie_rs2, b_perf_issued, b_perf_stalls;
  logic signed [15:0] b_scie_re, b_scie_im, b_rd_re, b_rd_im, b_out_re, b_out_im;
  logic [7:0]         b_out_seq;

  scie_issuer #(.LATENCY(1), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(a_in_ready), .io_in_insn(in_insn),
    .io_in_rs1_real(in_re), .io_in_rs1_imag(in_im), .io_in_rs2(in_rs2),
    .io_scie_valid(a_scie_valid), .io_scie_insn(a_scie_insn), .io_scie_rs2(a_scie_rs2),
    .io_scie_rs1_real(a_scie_re), .io_scie_rs1_imag(a_scie_im),
    .io_scie_rd_real(a_rd_re), .io_scie_rd_imag(a_rd_im),
    .io_out_valid(a_out_valid), .io_out_ready(out_ready),
    .io_out_real(a_out_re), .io_out_imag(a_out_im), .io_out_seq(a_out_seq),
    .io_perf_issued(a_perf_issued), .io_perf_stalls(a_perf_stalls)
  );

  scie_issuer #(.LATENCY(4), .DEPTH(DEPTH)) dut4 (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(b_in_ready), .io_in_insn(in_insn),
    .io_in_rs1_real(in_re), .io_in_rs1_imag(in_im), .io_in_rs2(in_rs2),
    .io_scie_valid(b_scie_valid), .io_scie_insn(b_scie_insn), .io_scie_rs2(b_scie_rs2),
    .io_scie_rs1_real(b_scie_re), .io_scie_rs1_imag(b_scie_im),
    .io_scie_rd_real(b_rd_re), .io_scie_rd_imag(b_rd_im),
    .io_out_valid(b_out_valid), .io_out_ready(out_ready),
    .io_out_real(b_out_re), .io_out_imag(b_out_im), .io_out_seq(b_out_seq),
    .io_perf_issued(b_perf_issued), .io_perf_stalls(b_perf_stalls)
  );

  // Echo SCIE stubs: rd is rs1 delayed by the unit latency.
  always @(posedge clock) begin
    a_rd_re <= a_scie_re;
    a_rd_im <= a_scie_im;
  end

  logic signed [15:0] b_pipe_re [4];
  logic signed [15:0] b_pipe_im [4];
  always @(posedge clock) begin
    b_pipe_re[0] <= b_scie_re;
    b_pipe_im[0] <= b_scie_im;
    for (int i = 1; i < 4; i++) begin
      b_pipe_re[i] <= b_pipe_re[i-1];
      b_pipe_im[i] <= b_pipe_im[i-1];
    end
  end
  assign b_rd_re = b_pipe_re[3];
  assign b_rd_im = b_pipe_im[3];

  // Reference model for the LATENCY=1 instance.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [7:0]         seq;
  } res_t;

  res_t       q[$];
  logic [7:0] m_seq;
  int         m_issued, m_stalls;
  bit         last_acc;
  int         checks = 0;
  int         errors = 0;

  // Advance one clock; the model applies the handshakes of that edge.
  task automatic tick();
    res_t r;
    bit can_accept;
    @(negedge clock);
    can_accept = (q.size() < DEPTH);
    last_acc = in_valid && can_accept;
    if (in_valid && !can_accept) m_stalls++;
    if (a_out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    if (last_acc) begin
      r.re = in_re; r.im = in_im; r.seq = m_seq;
      q.push_back(r);
      m_seq++;
      m_issued++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [31:0] insn, input logic signed [15:0] re,
                         input logic signed [15:0] im);
    in_valid = 1'b1;
    in_insn  = insn;
    in_re    = re;
    in_im    = im;
    in_rs2   = $urandom;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    q.delete();
    m_seq = 8'd0;
    m_issued = 0;
    m_stalls = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({a_scie_valid, a_scie_insn, a_scie_rs2, a_scie_re, a_scie_im, a_out_valid,
         a_out_re, a_out_im, a_out_seq, a_perf_issued, a_perf_stalls} !== '0) begin
      errors++;
      $display("FAIL reset_zero: outputs got %h required 0",
               {a_scie_valid, a_scie_insn, a_scie_rs2, a_scie_re, a_scie_im, a_out_valid,
                a_out_re, a_out_im, a_out_seq});
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", a_in_ready);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_scie_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_lat4: ready/out_valid/scie_valid got %b required 100",
                         {b_in_ready, b_out_valid, b_scie_valid});
    end
  endtask

  task automatic test_single();
    logic [31:0] rs2;
    reset_dut();
    set_req(32'd11, 16'sd59, -16'sd962);
    rs2 = in_rs2;
    tick();  // accept edge E0
    checks++;
    if ({a_scie_valid, a_scie_insn, a_scie_re, a_scie_im, a_scie_rs2} !==
        {1'b1, 32'd11, 16'sd59, -16'sd962, rs2}) begin
      errors++; $display("FAIL single_issue: valid=%b insn=%0d re=%0d im=%0d required 1 11 59 -962",
                         a_scie_valid, a_scie_insn, a_scie_re, a_scie_im);
    end
    in_valid = 1'b0;
    in_insn = $urandom;
    tick();  // E1
    checks++;
    if ({a_scie_valid, a_scie_insn, a_out_valid} !== {1'b0, 32'd11, 1'b0}) begin
      errors++; $display("FAIL single_hold: valid=%b insn=%0d out_valid=%b required 0 11 0",
                         a_scie_valid, a_scie_insn, a_out_valid);
    end
    tick();  // E2
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: out_valid got %b required 0 at E2", a_out_valid);
    end
    tick();  // E3
    checks++;
    if ({a_out_valid, a_out_re, a_out_im, a_out_seq} !== {1'b1, 16'sd59, -16'sd962, 8'd0}) begin
      errors++; $display("FAIL single_result: valid=%b re=%0d im=%0d seq=%0d required 1 59 -962 0",
                         a_out_valid, a_out_re, a_out_im, a_out_seq);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: out_valid got %b required 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    out_ready = 1'b1;
    set_req($urandom, 16'sd59, -16'sd962);
    tick();  // E0
    set_req($urandom, 16'sd1013, -16'sd8358);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready0: got %b required 1", a_in_ready);
    end
    tick();  // E1
    in_valid = 1'b0;
    checks++;
    if ({a_in_ready, a_scie_valid, a_scie_re} !== {1'b1, 1'b1, 16'sd1013}) begin
      errors++; $display("FAIL b2b_issue2: ready=%b scie_valid=%b re=%0d required 1 1 1013",
                         a_in_ready, a_scie_valid, a_scie_re);
    end
    tick();  // E2
    tick();  // E3
    checks++;
    if ({a_out_valid, a_out_re, a_out_im, a_out_seq} !== {1'b1, 16'sd59, -16'sd962, 8'd0}) begin
      errors++; $display("FAIL b2b_first: valid=%b re=%0d im=%0d seq=%0d required 1 59 -962 0",
                         a_out_valid, a_out_re, a_out_im, a_out_seq);
    end
    tick();  // E4
    checks++;
    if ({a_out_valid, a_out_re, a_out_im, a_out_seq} !== {1'b1, 16'sd1013, -16'sd8358, 8'd1}) begin
      errors++; $display("FAIL b2b_second: valid=%b re=%0d im=%0d seq=%0d required 1 1013 -8358 1",
                         a_out_valid, a_out_re, a_out_im, a_out_seq);
    end
    tick();  // E5
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: out_valid got %b required 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int issued_seen = 0;
    int popped = 0;
    reset_dut();
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 6) set_req($urandom, 16'($urandom), 16'($urandom));
      else in_valid = 1'b0;
      tick();
      if (last_acc) sent++;
      if (a_scie_valid) issued_seen++;
    end
    checks++;
    if (issued_seen !== 4) begin
      errors++; $display("FAIL bp_accepted: got %0d required 4", issued_seen);
    end
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %b required 0", a_in_ready);
    end
`ifdef SCIE_ISSUER_PERF_EN
    checks++;
    if ({a_perf_issued, a_perf_stalls} !== {32'd4, 32'(m_stalls)}) begin
      errors++; $display("FAIL bp_perf: issued=%0d stalls=%0d required 4 %0d",
                         a_perf_issued, a_perf_stalls, m_stalls);
    end
`else
    checks++;
    if ({a_perf_issued, a_perf_stalls} !== 64'd0) begin
      errors++; $display("FAIL bp_perf_off: issued=%0d stalls=%0d required 0 0",
                         a_perf_issued, a_perf_stalls);
    end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 60 && popped < 6; c++) begin
      if (sent < 6) set_req($urandom, 16'($urandom), 16'($urandom));
      else in_valid = 1'b0;
      if (a_out_valid) begin
        checks++;
        if (q.size() == 0 || {a_out_re, a_out_im, a_out_seq} !== {q[0].re, q[0].im, q[0].seq}) begin
          errors++; $display("FAIL bp_drain: re=%0d im=%0d seq=%0d unexpected (model entries %0d)",
                             a_out_re, a_out_im, a_out_seq, q.size());
        end
        popped++;
      end
      tick();
      if (last_acc) sent++;
      if (a_scie_valid) issued_seen++;
    end
    checks++;
    if ({popped, issued_seen} !== {32'd6, 32'd6}) begin
      errors++; $display("FAIL bp_total: popped=%0d issued=%0d required 6 6", popped, issued_seen);
    end
  endtask

  task automatic test_seq_wrap();
    int sent = 0;
    int popped = 0;
    reset_dut();
    out_ready = 1'b1;
    for (int c = 0; c < 2000 && popped < 257; c++) begin
      if (sent < 257) set_req($urandom, 16'($urandom), 16'($urandom));
      else in_valid = 1'b0;
      if (a_out_valid) begin
        popped++;
        if (q.size() == 0 || {a_out_re, a_out_im, a_out_seq} !== {q[0].re, q[0].im, q[0].seq}) begin
          checks++; errors++;
          $display("FAIL wrap_data: result %0d re=%0d im=%0d seq=%0d unexpected",
                   popped, a_out_re, a_out_im, a_out_seq);
        end
        if (popped == 256) begin
          checks++;
          if (a_out_seq !== 8'd255) begin
            errors++; $display("FAIL wrap_256: seq got %0d required 255", a_out_seq);
          end
        end
        if (popped == 257) begin
          checks++;
          if (a_out_seq !== 8'd0) begin
            errors++; $display("FAIL wrap_257: seq got %0d required 0", a_out_seq);
          end
        end
      end
      tick();
      if (last_acc) sent++;
    end
    checks++;
    if (popped !== 257) begin
      errors++; $display("FAIL wrap_total: popped %0d required 257", popped);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    logic signed [15:0] re, im;
    reset_dut();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req($urandom, 16'($urandom), 16'($urandom));
      tick();
    end
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_scie_valid} !== 3'b010) begin
      errors++; $display("FAIL midreset_now: out_valid/ready/scie_valid got %b required 010",
                         {a_out_valid, a_in_ready, a_scie_valid});
    end
    q.delete();
    m_seq = 8'd0;
    m_issued = 0;
    m_stalls = 0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (a_out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_stale: out_valid seen %0d cycles required 0", seen);
    end
    re = 16'($urandom);
    im = 16'($urandom);
    set_req($urandom, re, im);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (a_out_valid) begin
        seen = 1;
        checks++;
        if ({a_out_re, a_out_im, a_out_seq} !== {re, im, 8'd0}) begin
          errors++; $display("FAIL midreset_first: re=%0d im=%0d seq=%0d required %0d %0d 0",
                             a_out_re, a_out_im, a_out_seq, re, im);
        end
      end
      tick();
    end
    checks++;
    if (seen !== 1) begin
      errors++; $display("FAIL midreset_timeout: result seen %0d required 1", seen);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_insn = $urandom;
      in_rs2 = $urandom;
      in_re = 16'($urandom);
      in_im = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (a_in_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rand_ready: cycle %0d got %b required %b",
                           c, a_in_ready, (q.size() < DEPTH));
      end
      if (a_out_valid) begin
        checks++;
        if (q.size() == 0 || {a_out_re, a_out_im, a_out_seq} !== {q[0].re, q[0].im, q[0].seq}) begin
          errors++; $display("FAIL rand_data: cycle %0d re=%0d im=%0d seq=%0d unexpected",
                             c, a_out_re, a_out_im, a_out_seq);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      if (a_out_valid) begin
        checks++;
        if ({a_out_re, a_out_im, a_out_seq} !== {q[0].re, q[0].im, q[0].seq}) begin
          errors++; $display("FAIL rand_drain: re=%0d im=%0d seq=%0d required %0d %0d %0d",
                             a_out_re, a_out_im, a_out_seq, q[0].re, q[0].im, q[0].seq);
        end
      end
      tick();
    end
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL rand_left: %0d results never delivered, required 0", q.size());
    end
`ifdef SCIE_ISSUER_PERF_EN
    checks++;
    if ({a_perf_issued, a_perf_stalls} !== {32'(m_issued), 32'(m_stalls)}) begin
      errors++; $display("FAIL rand_perf: issued=%0d stalls=%0d required %0d %0d",
                         a_perf_issued, a_perf_stalls, m_issued, m_stalls);
    end
`else
    checks++;
    if ({a_perf_issued, a_perf_stalls} !== 64'd0) begin
      errors++; $display("FAIL rand_perf_off: issued=%0d stalls=%0d required 0 0",
                         a_perf_issued, a_perf_stalls);
    end
`endif
  endtask

  task automatic test_latency4();
    int a_first = -1;
    int b_first = -1;
    logic signed [15:0] re, im, b_re, b_im;
    logic [7:0] b_seq;
    reset_dut();
    out_ready = 1'b1;
    re = 16'($urandom);
    im = 16'($urandom);
    set_req($urandom, re, im);
    tick();  // E0
    in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (a_out_valid && a_first < 0) a_first = n;
      if (b_out_valid && b_first < 0) begin
        b_first = n;
        b_re = b_out_re; b_im = b_out_im; b_seq = b_out_seq;
      end
    end
    checks++;
    if (a_first !== 3) begin
      errors++; $display("FAIL lat1_edges: got %0d required 3", a_first);
    end
    checks++;
    if (b_first !== 6) begin
      errors++; $display("FAIL lat4_edges: got %0d required 6", b_first);
    end
    else begin
      checks++;
      if ({b_re, b_im, b_seq} !== {re, im, 8'd0}) begin
        errors++; $display("FAIL lat4_data: re=%0d im=%0d seq=%0d required %0d %0d 0",
                           b_re, b_im, b_seq, re, im);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_seq_wrap();
    test_reset_midflight();
    test_random();
    test_latency4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/scie_issuer.md
# scie_issuer

Request-side companion to the pipelined SCIE complex-arithmetic unit. Accepts complex operand/instruction requests on a valid/ready stream, drives the SCIE issue port (`valid`, `insn`, `rs1`, `rs2`), and captures each `rd` result a fixed `LATENCY` later. Results are buffered in a result FIFO and presented on a valid/ready output stream with a sequence tag. Credit-based admission guarantees that no result is ever dropped, since the SCIE unit itself has no stall.

## Interface

**Parameters**
- `LATENCY`, default 1: cycles from the SCIE `valid` cycle to the cycle in which `rd` is valid. Legal range 1–8.
- `DEPTH`, default 4: result FIFO entries, which is also the total credit count. Power of two, 2–16.

**Ports** (clock and reset first)
- `clock` (in, 1): single clock, rising edge.
- `reset` (in, 1): asynchronous, active-high.
- `io_in_valid` (in, 1): request valid.
- `io_in_ready` (out, 1): request ready.
- `io_in_insn` (in, 32): instruction word forwarded to SCIE.
- `io_in_rs1_real`, `io_in_rs1_imag` (in, 16 each, signed): complex operand.
- `io_in_rs2` (in, 32): second operand.
- `io_scie_valid` (out, 1): issue strobe to SCIE.
- `io_scie_insn` (out, 32), `io_scie_rs2` (out, 32): issued fields.
- `io_scie_rs1_real`, `io_scie_rs1_imag` (out, 16 each, signed): issued operand.
- `io_scie_rd_real`, `io_scie_rd_imag` (in, 16 each, signed): SCIE result.
- `io_out_valid` (out, 1), `io_out_ready` (in, 1): result stream handshake.
- `io_out_real`, `io_out_imag` (out, 16 each, signed): result, passed bit-exact with no width change.
- `io_out_seq` (out, 8): sequence tag of the originating request.
- `io_perf_issued` (out, 32), `io_perf_stalls` (out, 32): performance counters (see Configuration).

## Operation
- **Accept** when `io_in_valid && io_in_ready` at a rising edge. On the next cycle, drive `io_scie_valid=1` for exactly one cycle. The `io_scie_*` fields are registered copies of the request.
- **Idle issue port:** when no request is accepted, `io_scie_valid=0` and the `io_scie_*` data fields hold their last values.
- **Tag pipeline:** a `LATENCY`-deep shift register carries a valid bit plus the 8-bit seq. When the valid bit exits, `io_scie_rd_*` is written into the FIFO with that seq.
- **Seq counter:** increments per accepted request, wrapping 255→0. Reset value 0.
- **Credits:** `used` = FIFO occupancy + issue register + tag-pipeline valids.
  - `io_in_ready = (used < DEPTH)`, computed from registered state only and independent of `io_in_valid`.
  - Simultaneous accept and pop leaves `used` unchanged.
  - A FIFO write can never find the FIFO full.
- **FIFO:** first-word-fall-through. `io_out_valid` = not empty; a pop occurs on `io_out_valid && io_out_ready`.
  - Same-cycle write into an empty FIFO is not bypassed: `io_out_valid` rises the cycle after the write.
  - Simultaneous write and pop on a non-empty FIFO keeps occupancy constant.
- **Back-to-back requests:** supported at one per cycle while credits remain.

## Timing
- **Reset values** (all outputs, applied immediately on `reset` assertion regardless of clock):
  - Zero: `io_scie_valid`, `io_scie_*` data, `io_out_valid`, `io_out_real`, `io_out_imag`, `io_out_seq`, perf counters.
  - `io_in_ready=1`.
- **End-to-end:** accept at edge E0 → `io_scie_valid` high E0..E1 → `rd` sampled at edge E(1+LATENCY) → `io_out_valid` high from edge E(2+LATENCY).
- **Reset mid-operation:** in-flight and buffered results are discarded; the seq counter restarts at 0. SCIE outputs returned after reset release are ignored because the tag valids were cleared.
- **Throughput:** with `io_out_ready` held at 1, sustained 1 result/cycle. With `io_out_ready=0`, exactly `DEPTH` requests are accepted, then `io_in_ready=0`.

## Configuration
- **`SCIE_ISSUER_PERF_EN` defined:**
  - `io_perf_issued` counts accepted requests.
  - `io_perf_stalls` counts cycles with `io_in_valid && !io_in_ready`.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- **Not defined:** both perf outputs are tied to constant 0 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- **Single request, LATENCY=1, echo model** (SCIE stub returns `rs1` delayed 1 cycle): request `insn=11`, `rs1=(59,-962)` → `io_scie_valid` pulses 1 cycle with `insn=11`; `io_out_valid` is observed 3 edges after accept with `(59,-962)`, `seq=0`.
- **Back-to-back issue:** `(59,-962)` then `(1013,-8358)` on consecutive cycles with `io_out_ready=1` → results appear in order on consecutive cycles with `seq` 0 then 1, and `io_in_ready` stays 1.
- **Backpressure:** `io_out_ready=0`, `DEPTH=4`, 6 requests offered → exactly 4 accepted and `io_in_ready=0`; `io_perf_stalls` increments each blocked cycle (PERF_EN only). Raising `io_out_ready` drains in order and re-admits the remaining 2 requests.
- **Seq wrap:** 257 requests → the 256th result carries `seq=255` and the 257th carries `seq=0`.
- **Reset mid-flight:** assert `reset` asynchronously between edges with 3 results in flight → `io_out_valid` is 0 immediately and `io_in_ready=1`. The first post-reset request returns `seq=0`.
- **LATENCY=4 build:** single request → `io_out_valid` is observed exactly 6 edges after accept, and the value matches the echo model.
